// File: rtl/carrier_nco_epoch_ctrl.sv
// ============================================================================
// carrier_nco_epoch_ctrl : epoch-gated carrier NCO phase sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module carrier_nco_epoch_ctrl #(
    parameter int DSIZE = 32,
    parameter int CNT_W = 16
) (
    input  logic             axis_aclk,
    input  logic             i_reset,
    input  logic             i_start_tracking,
    input  logic             i_delay_ready,
    input  logic             i_raw_data_valid,
    input  logic [DSIZE-1:0] i_cfg_phase_step,
    input  logic [DSIZE-1:0] i_cfg_rem_phase,
    input  logic [DSIZE-1:0] i_cfg_step_rate,
    input  logic [DSIZE-1:0] i_cfg_corr_length,
    input  logic             i_cfg_load,
    output logic             o_cfg_pending,
    output logic [DSIZE-1:0] o_phase,
    output logic             o_phase_valid,
    output logic [DSIZE-1:0] o_sample_index,
    output logic             o_epoch_done,
    output logic [CNT_W-1:0] o_epoch_count,
    output logic [DSIZE-1:0] o_rem_phase_out,
    output logic [1:0]       o_state
);

    localparam logic [DSIZE-1:0] C_ONE  = DSIZE'(1);
    localparam logic [CNT_W-1:0] C_CONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DSIZE-1:0] sh_step_q, sh_rem_q, sh_rate_q, sh_len_q;
    logic [DSIZE-1:0] sh_step_d, sh_rem_d, sh_rate_d, sh_len_d;
    logic             pending_q, pending_d;
    logic [DSIZE-1:0] act_step_q, act_rem_q, act_rate_q, act_len_q;
    logic [DSIZE-1:0] act_step_d, act_rem_d, act_rate_d, act_len_d;
    logic [DSIZE-1:0] phase_q, step_q, idx_q;
    logic [DSIZE-1:0] phase_d, step_d, idx_d;
    logic [DSIZE-1:0] ophase_q, ophase_d, oidx_q, oidx_d, rem_out_q, rem_out_d;
    logic             ovalid_q, ovalid_d, done_q, done_d;
    logic [CNT_W-1:0] ecount_q, ecount_d;

    logic             w_accept;
    logic             w_last;
    logic [DSIZE-1:0] w_len_m1;
    logic [DSIZE-1:0] w_phase_nx;

    assign w_accept   = (state_q == ST_TRACK) && i_delay_ready && i_raw_data_valid;
    // A zero length behaves as a one-sample epoch.
    assign w_len_m1   = (act_len_q == '0) ? '0 : act_len_q - C_ONE;
    assign w_last     = (idx_q >= w_len_m1);
    assign w_phase_nx = phase_q + step_q;

    always_ff @(posedge axis_aclk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sh_step_d  = sh_step_q;
        sh_rem_d   = sh_rem_q;
        sh_rate_d  = sh_rate_q;
        sh_len_d   = sh_len_q;
        pending_d  = pending_q;
        act_step_d = act_step_q;
        act_rem_d  = act_rem_q;
        act_rate_d = act_rate_q;
        act_len_d  = act_len_q;
        phase_d    = phase_q;
        step_d     = step_q;
        idx_d      = idx_q;
        ophase_d   = ophase_q;
        oidx_d     = oidx_q;
        rem_out_d  = rem_out_q;
        ovalid_d   = 1'b0;
        done_d     = 1'b0;
        ecount_d   = ecount_q;

        case (state_q)
            ST_IDLE: begin
                oidx_d = '0;
                if (i_start_tracking) begin
                    state_d = ST_ALIGN;
                    idx_d   = '0;
                    if (pending_q) begin
                        {act_step_d, act_rem_d, act_rate_d, act_len_d} =
                            {sh_step_q, sh_rem_q, sh_rate_q, sh_len_q};
                        pending_d = 1'b0;
                        phase_d   = sh_rem_q;
                        step_d    = sh_step_q;
                    end else begin
                        phase_d = act_rem_q;
                        step_d  = act_step_q;
                    end
                end
            end
            ST_ALIGN: begin
                if (!i_start_tracking) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    oidx_d  = '0;
                end else if (i_delay_ready) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (w_accept) begin
                    ovalid_d = 1'b1;
                    ophase_d = phase_q;
                    oidx_d   = idx_q;
                end
                // Dropping the channel abandons the partial epoch silently.
                if (!i_start_tracking) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    if (!w_accept) begin
                        oidx_d = '0;
                    end
                end else if (!i_delay_ready) begin
                    state_d = ST_ALIGN;
                end else if (w_accept) begin
                    if (w_last) begin
                        done_d    = 1'b1;
                        ecount_d  = ecount_q + C_CONE;
                        rem_out_d = w_phase_nx;
                        idx_d     = '0;
                        if (pending_q) begin
                            {act_step_d, act_rem_d, act_rate_d, act_len_d} =
                                {sh_step_q, sh_rem_q, sh_rate_q, sh_len_q};
                            pending_d = 1'b0;
                            phase_d   = sh_rem_q;
                            step_d    = sh_step_q;
                        end else begin
                            phase_d = w_phase_nx;
                            step_d  = act_step_q;
                        end
                    end else begin
                        phase_d = w_phase_nx;
                        step_d  = step_q + act_rate_q;
                        idx_d   = idx_q + C_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load coinciding with an apply lands in the shadow for the next one.
        if (i_cfg_load) begin
            sh_step_d = i_cfg_phase_step;
            sh_rem_d  = i_cfg_rem_phase;
            sh_rate_d = i_cfg_step_rate;
            sh_len_d  = i_cfg_corr_length;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (i_reset) begin
            sh_step_q  <= '0;
            sh_rem_q   <= '0;
            sh_rate_q  <= '0;
            sh_len_q   <= '0;
            pending_q  <= 1'b0;
            act_step_q <= '0;
            act_rem_q  <= '0;
            act_rate_q <= '0;
            act_len_q  <= '0;
            phase_q    <= '0;
            step_q     <= '0;
            idx_q      <= '0;
            ophase_q   <= '0;
            oidx_q     <= '0;
            rem_out_q  <= '0;
            ovalid_q   <= 1'b0;
            done_q     <= 1'b0;
            ecount_q   <= '0;
        end else begin
            sh_step_q  <= sh_step_d;
            sh_rem_q   <= sh_rem_d;
            sh_rate_q  <= sh_rate_d;
            sh_len_q   <= sh_len_d;
            pending_q  <= pending_d;
            act_step_q <= act_step_d;
            act_rem_q  <= act_rem_d;
            act_rate_q <= act_rate_d;
            act_len_q  <= act_len_d;
            phase_q    <= phase_d;
            step_q     <= step_d;
            idx_q      <= idx_d;
            ophase_q   <= ophase_d;
            oidx_q     <= oidx_d;
            rem_out_q  <= rem_out_d;
            ovalid_q   <= ovalid_d;
            done_q     <= done_d;
            ecount_q   <= ecount_d;
        end
    end

    assign o_cfg_pending   = pending_q;
    assign o_phase         = ophase_q;
    assign o_phase_valid   = ovalid_q;
    assign o_sample_index  = oidx_q;
    assign o_epoch_done    = done_q;
    assign o_epoch_count   = ecount_q;
    assign o_rem_phase_out = rem_out_q;
    assign o_state         = state_q;

endmodule

`default_nettype wire
